mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
Multi-cycle main controller for the MIPS-subset core: R-type, lw, sw, ori, addiu, addi, beq, j. It replaces single-cycle decode with a state machine that sequences one shared ALU and one unified instruction/data memory over several cycles. Memory accesses use a req/ready handshake. The block sits between the IR opcode field and the multi-cycle datapath muxes and enables, and also provides retire/illegal status.

Parameters:
CNT_W, 16, width of retired-instruction counter
OP_R, 6'b000000, R-type opcode (likewise OP_LW 100011, OP_SW 101011, OP_ORI 001101, OP_ADDIU 001001, OP_ADDI 001000, OP_BEQ 000100, OP_J 000010)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
op  in  6  IR[31:26], valid from DECODE onward
mem_ready  in  1  memory completes the current access this cycle
PCWr  out  1  unconditional PC write
PCWrCond  out  1  PC write if ALU zero (beq)
IorD  out  1  memory address: 0=PC, 1=ALUOut
MemRd  out  1  memory read request
MemWr  out  1  memory write request
IRWr  out  1  instruction register load
RegDst  out  1  1=rd, 0=rt
RegWr  out  1  register file write
MemtoReg  out  1  1=MDR, 0=ALUOut
ExtOp  out  1  1=sign-extend, 0=zero-extend imm16
ALUSrcA  out  1  0=PC, 1=reg A
ALUSrcB  out  2  00=reg B, 01=const 4, 10=ext imm, 11=ext imm<<2
ALUOp  out  2  00=add, 01=sub, 10=use funct, 11=or
PCSrc  out  2  00=ALU result, 01=ALUOut, 10=jump target
state_o  out  4  current state encoding (debug)
retire  out  1  one-cycle pulse when an instruction completes
illegal  out  1  one-cycle pulse on unsupported opcode
instr_cnt  out  CNT_W  retired-instruction count, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, rst_n=0): state=FETCH (0), instr_cnt=0, op_q=0. retire and illegal are registered pulses and reset to 0. All other outputs are Moore/decode outputs; they take their FETCH values immediately.
- A reset during any state aborts the instruction. No write strobe may remain asserted after rst_n falls.
- States and encoding: FETCH 0, DECODE 1, MEM_ADR 2, MEM_RD 3, WB_MEM 4, MEM_WR 5, EXE_R 6, WB_R 7, EXE_I 8, WB_I 9, BRANCH 10, JUMP 11.
- Outputs default to 0 in every state except where listed below.
- FETCH: MemRd=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00. IRWr and PCWr equal mem_ready. Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: latch op into op_q. ALUSrcA=0, ALUSrcB=11, ExtOp=1, ALUOp=00 (precompute branch target). Next state by op:
  - R -> EXE_R
  - lw, sw -> MEM_ADR
  - ori, addiu, addi -> EXE_I
  - beq -> BRANCH
  - j -> JUMP
  - any other op -> FETCH, with illegal pulsing in the next cycle; instr_cnt is not incremented.
- Later states decode from op_q only; a change on op after DECODE has no effect.
- MEM_ADR: ALUSrcA=1, ALUSrcB=10, ExtOp=1, ALUOp=00. Next state is MEM_RD for lw, MEM_WR for sw.
- MEM_RD: MemRd=1, IorD=1. Hold until mem_ready, then go to WB_MEM.
- WB_MEM: RegWr=1, RegDst=0, MemtoReg=1, then FETCH.
- MEM_WR: MemWr=1, IorD=1. Hold MemWr until mem_ready, then FETCH. The instruction retires on the mem_ready cycle.
- EXE_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10, then WB_R.
- WB_R: RegWr=1, RegDst=1, MemtoReg=0, then FETCH.
- EXE_I: ALUSrcA=1, ALUSrcB=10. ExtOp=0 for ori, 1 otherwise. ALUOp=11 for ori, 00 otherwise. Then WB_I.
- WB_I: RegWr=1, RegDst=0, MemtoReg=0, then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWrCond=1, PCSrc=01, then FETCH.
- JUMP: PCWr=1, PCSrc=10, then FETCH.
- Retire: retire pulses and instr_cnt increments in the cycle after leaving WB_MEM, WB_R, WB_I, BRANCH, JUMP, or MEM_WR (with mem_ready). Increment from all-ones wraps to 0.
- Latency with zero memory wait states: lw 5, sw 4, R 4, I-type 4, beq 3, j 3 cycles. Each memory wait cycle adds 1.
- Invariants: MemRd and MemWr are never both 1; RegWr=1 only in WB_* states.

Test Plan:
- Reset mid-instruction: rst_n low while in MEM_WR with MemWr=1 -> state_o=0 and MemWr=0 at once, instr_cnt=0; after release FETCH shows MemRd=1.
- R-type with mem_ready always 1: op=000000 -> state_o sequence 0,1,6,7,0; RegWr=1 and RegDst=1 only in state 7; retire pulses once; instr_cnt=1.
- lw with 2 wait states in each access: mem_ready low 2 cycles per access -> 9 cycles total; IRWr is a single cycle; WB_MEM has MemtoReg=1.
- sw followed by ori: sw gives MemWr held 3 cycles until mem_ready; ori EXE_I shows ExtOp=0, ALUOp=11; instr_cnt=2.
- beq then j: BRANCH shows PCWrCond=1, ALUOp=01, PCSrc=01; JUMP shows PCWr=1, PCSrc=10; each takes 3 cycles.
- Illegal op=111111 -> states 0,1,0, illegal pulses 1 cycle, instr_cnt unchanged. Preload near 2^CNT_W-1 via 65535 j instructions -> the next retire wraps instr_cnt to 0.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm -- multi-cycle main controller for the MIPS-subset core
// (R-type, lw, sw, ori, addiu, addi, beq, j).
// Sequences one shared ALU and one unified instruction/data memory over
// several cycles. Memory accesses use a req/ready handshake: the request
// (MemRd/MemWr) is held until mem_ready is seen.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   op                IR[31:26]; sampled in DECODE only
//   mem_ready         memory completes the current access this cycle
//   PCWr..PCSrc       datapath mux selects and write enables
//   state_o           current state encoding (debug)
//   retire, illegal   registered one-cycle status pulses
//   instr_cnt         retired-instruction count, wraps modulo 2^CNT_W
module mc_ctrl_fsm #(
    parameter int          CNT_W    = 16,
    parameter logic [5:0]  OP_R     = 6'b000000,
    parameter logic [5:0]  OP_LW    = 6'b100011,
    parameter logic [5:0]  OP_SW    = 6'b101011,
    parameter logic [5:0]  OP_ORI   = 6'b001101,
    parameter logic [5:0]  OP_ADDIU = 6'b001001,
    parameter logic [5:0]  OP_ADDI  = 6'b001000,
    parameter logic [5:0]  OP_BEQ   = 6'b000100,
    parameter logic [5:0]  OP_J     = 6'b000010
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       op,
    input  logic             mem_ready,
    output logic             PCWr,
    output logic             PCWrCond,
    output logic             IorD,
    output logic             MemRd,
    output logic             MemWr,
    output logic             IRWr,
    output logic             RegDst,
    output logic             RegWr,
    output logic             MemtoReg,
    output logic             ExtOp,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSrc,
    output logic [3:0]       state_o,
    output logic             retire,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEM_ADR = 4'd2,
        MEM_RD  = 4'd3,
        WB_MEM  = 4'd4,
        MEM_WR  = 4'd5,
        EXE_R   = 4'd6,
        WB_R    = 4'd7,
        EXE_I   = 4'd8,
        WB_I    = 4'd9,
        BRANCH  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    state_t     state, nextState;
    logic [5:0] opQ;
    logic       retireD, illegalD;
    logic       isOri;

    assign state_o = state;
    assign isOri   = (opQ == OP_ORI);

    // Opcode is captured once in DECODE; every later state steers off opQ
    // so a changing IR field cannot disturb an instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH;
            opQ       <= '0;
            retire    <= 1'b0;
            illegal   <= 1'b0;
            instr_cnt <= '0;
        end else begin
            state   <= nextState;
            retire  <= retireD;
            illegal <= illegalD;
            if (state == DECODE) opQ <= op;
            if (retireD) instr_cnt <= instr_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        nextState = state;
        retireD   = 1'b0;
        illegalD  = 1'b0;
        PCWr      = 1'b0;
        PCWrCond  = 1'b0;
        IorD      = 1'b0;
        MemRd     = 1'b0;
        MemWr     = 1'b0;
        IRWr      = 1'b0;
        RegDst    = 1'b0;
        RegWr     = 1'b0;
        MemtoReg  = 1'b0;
        ExtOp     = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        PCSrc     = 2'b00;
        case (state)
            FETCH: begin
                // PC+4 is computed every fetch cycle but only committed,
                // together with the IR load, when the memory delivers.
                MemRd   = 1'b1;
                ALUSrcB = 2'b01;
                IRWr    = mem_ready;
                PCWr    = mem_ready;
                if (mem_ready) nextState = DECODE;
            end
            DECODE: begin
                // ALU is idle here, so precompute the branch target.
                ALUSrcB = 2'b11;
                ExtOp   = 1'b1;
                case (op)
                    OP_R:                       nextState = EXE_R;
                    OP_LW, OP_SW:               nextState = MEM_ADR;
                    OP_ORI, OP_ADDIU, OP_ADDI:  nextState = EXE_I;
                    OP_BEQ:                     nextState = BRANCH;
                    OP_J:                       nextState = JUMP;
                    default: begin
                        nextState = FETCH;
                        illegalD  = 1'b1;
                    end
                endcase
            end
            MEM_ADR: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ExtOp     = 1'b1;
                nextState = (opQ == OP_SW) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                MemRd = 1'b1;
                IorD  = 1'b1;
                if (mem_ready) nextState = WB_MEM;
            end
            WB_MEM: begin
                RegWr     = 1'b1;
                MemtoReg  = 1'b1;
                retireD   = 1'b1;
                nextState = FETCH;
            end
            MEM_WR: begin
                MemWr = 1'b1;
                IorD  = 1'b1;
                if (mem_ready) begin
                    retireD   = 1'b1;
                    nextState = FETCH;
                end
            end
            EXE_R: begin
                ALUSrcA   = 1'b1;
                ALUOp     = 2'b10;
                nextState = WB_R;
            end
            WB_R: begin
                RegWr     = 1'b1;
                RegDst    = 1'b1;
                retireD   = 1'b1;
                nextState = FETCH;
            end
            EXE_I: begin
                // ori is a logical op: zero-extend and OR; the adds sign-extend.
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ExtOp     = ~isOri;
                ALUOp     = isOri ? 2'b11 : 2'b00;
                nextState = WB_I;
            end
            WB_I: begin
                RegWr     = 1'b1;
                retireD   = 1'b1;
                nextState = FETCH;
            end
            BRANCH: begin
                ALUSrcA   = 1'b1;
                ALUOp     = 2'b01;
                PCWrCond  = 1'b1;
                PCSrc     = 2'b01;
                retireD   = 1'b1;
                nextState = FETCH;
            end
            JUMP: begin
                PCWr      = 1'b1;
                PCSrc     = 2'b10;
                retireD   = 1'b1;
                nextState = FETCH;
            end
            default: nextState = FETCH;
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
module tb_mc_ctrl_fsm;

    localparam int CW = 8;

    localparam logic [5:0] O_R = 6'b000000, O_LW = 6'b100011, O_SW = 6'b101011,
                           O_ORI = 6'b001101, O_ADDIU = 6'b001001, O_ADDI = 6'b001000,
                           O_BEQ = 6'b000100, O_J = 6'b000010, O_BAD = 6'b111111;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [5:0]    op;
    logic          mem_ready;
    logic          PCWr, PCWrCond, IorD, MemRd, MemWr, IRWr, RegDst, RegWr;
    logic          MemtoReg, ExtOp, ALUSrcA;
    logic [1:0]    ALUSrcB, ALUOp, PCSrc;
    logic [3:0]    state_o;
    logic          retire, illegal;
    logic [CW-1:0] instr_cnt;

    mc_ctrl_fsm #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
        .PCWr(PCWr), .PCWrCond(PCWrCond), .IorD(IorD), .MemRd(MemRd),
        .MemWr(MemWr), .IRWr(IRWr), .RegDst(RegDst), .RegWr(RegWr),
        .MemtoReg(MemtoReg), .ExtOp(ExtOp), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .state_o(state_o),
        .retire(retire), .illegal(illegal), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       PCWr, PCWrCond, IorD, MemRd, MemWr, IRWr, RegDst, RegWr;
        logic       MemtoReg, ExtOp, ALUSrcA;
        logic [1:0] ALUSrcB, ALUOp, PCSrc;
    } ctrl_t;

    ctrl_t dutC;
    assign dutC = {PCWr, PCWrCond, IorD, MemRd, MemWr, IRWr, RegDst, RegWr,
                   MemtoReg, ExtOp, ALUSrcA, ALUSrcB, ALUOp, PCSrc};

    localparam ctrl_t C_F0   = '{MemRd:1'b1, ALUSrcB:2'b01, default:'0};
    localparam ctrl_t C_F1   = '{PCWr:1'b1, IRWr:1'b1, MemRd:1'b1, ALUSrcB:2'b01, default:'0};
    localparam ctrl_t C_DEC  = '{ALUSrcB:2'b11, ExtOp:1'b1, default:'0};
    localparam ctrl_t C_MADR = '{ALUSrcA:1'b1, ALUSrcB:2'b10, ExtOp:1'b1, default:'0};
    localparam ctrl_t C_MRD  = '{MemRd:1'b1, IorD:1'b1, default:'0};
    localparam ctrl_t C_WBM  = '{RegWr:1'b1, MemtoReg:1'b1, default:'0};
    localparam ctrl_t C_MWR  = '{MemWr:1'b1, IorD:1'b1, default:'0};
    localparam ctrl_t C_EXR  = '{ALUSrcA:1'b1, ALUOp:2'b10, default:'0};
    localparam ctrl_t C_WBR  = '{RegWr:1'b1, RegDst:1'b1, default:'0};
    localparam ctrl_t C_EXIO = '{ALUSrcA:1'b1, ALUSrcB:2'b10, ALUOp:2'b11, default:'0};
    localparam ctrl_t C_WBI  = '{RegWr:1'b1, default:'0};
    localparam ctrl_t C_BR   = '{ALUSrcA:1'b1, ALUOp:2'b01, PCWrCond:1'b1, PCSrc:2'b01, default:'0};
    localparam ctrl_t C_J    = '{PCWr:1'b1, PCSrc:2'b10, default:'0};

    typedef struct {
        logic [5:0] op;
        bit         rdy;
        int         st;
        ctrl_t      c;
        bit         ret;
        bit         ill;
        int         cnt;
    } vec_t;

    vec_t vq[$];
    int   nChk = 0;
    int   nErr = 0;

    // reference-model state
    logic [CW-1:0] mCnt;
    bit            pendRet, pendIll;

    task automatic chk(input string name, input int act, input int exp);
        nChk++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic addv(input logic [5:0] o, input bit r, input int s, input ctrl_t c,
                        input bit rt, input bit il, input int n);
        vq.push_back('{o, r, s, c, rt, il, n});
    endtask

    function automatic bit isLegal(input logic [5:0] o);
        return o inside {O_R, O_LW, O_SW, O_ORI, O_ADDIU, O_ADDI, O_BEQ, O_J};
    endfunction

    // Model: an instruction is a list of phases; a memory phase lasts
    // (waits+1) cycles and completes on its last cycle.
    task automatic runInstr(input logic [5:0] o, input int w1, input int w2);
        int  expS[$];
        bit  rdyQ[$];
        int  decIdx;
        bit  legal;
        legal = isLegal(o);
        for (int i = 0; i <= w1; i++) begin expS.push_back(0); rdyQ.push_back(i == w1); end
        decIdx = expS.size();
        expS.push_back(1); rdyQ.push_back(1'($urandom));
        case (o)
            O_R:  begin expS.push_back(6); expS.push_back(7); end
            O_LW: begin
                expS.push_back(2);
                for (int i = 0; i <= w2; i++) expS.push_back(3);
                expS.push_back(4);
            end
            O_SW: begin
                expS.push_back(2);
                for (int i = 0; i <= w2; i++) expS.push_back(5);
            end
            O_ORI, O_ADDIU, O_ADDI: begin expS.push_back(8); expS.push_back(9); end
            O_BEQ: expS.push_back(10);
            O_J:   expS.push_back(11);
            default: ;
        endcase
        // data-access phases: ready only on the final cycle of the access
        for (int k = decIdx + 1; k < expS.size(); k++) begin
            if (expS[k] == 3 || expS[k] == 5)
                rdyQ.push_back((k + 1 == expS.size()) || (expS[k+1] != expS[k]));
            else
                rdyQ.push_back(1'($urandom));
        end
        for (int k = 0; k < expS.size(); k++) begin
            @(negedge clk);
            mem_ready = rdyQ[k];
            op = (k == decIdx) ? o : 6'($urandom);
            #1;
            chk("state", int'(state_o), expS[k]);
            chk("retire", int'(retire), int'(k == 0 && pendRet));
            chk("illegal", int'(illegal), int'(k == 0 && pendIll));
            chk("instr_cnt", int'(instr_cnt), int'(mCnt));
            chk("strobes {MemRd,MemWr,RegWr}", int'({MemRd, MemWr, RegWr}),
                int'({expS[k] == 0 || expS[k] == 3, expS[k] == 5,
                      expS[k] == 4 || expS[k] == 7 || expS[k] == 9}));
        end
        pendRet = legal;
        pendIll = !legal;
        if (legal) mCnt = mCnt + 1'b1;
    endtask

    initial begin
        // directed cycle table: R, sw (2 waits), ori, beq, j, lw (2+2 waits), illegal
        addv(O_R,   1, 0,  C_F1,  0, 0, 0);
        addv(O_R,   1, 1,  C_DEC, 0, 0, 0);
        addv(O_LW,  1, 6,  C_EXR, 0, 0, 0);
        addv(O_J,   1, 7,  C_WBR, 0, 0, 0);
        addv(O_BAD, 1, 0,  C_F1,  1, 0, 1);
        addv(O_SW,  1, 1,  C_DEC, 0, 0, 1);
        addv(O_LW,  1, 2,  C_MADR,0, 0, 1);
        addv(O_LW,  0, 5,  C_MWR, 0, 0, 1);
        addv(O_R,   0, 5,  C_MWR, 0, 0, 1);
        addv(O_R,   1, 5,  C_MWR, 0, 0, 1);
        addv(O_R,   1, 0,  C_F1,  1, 0, 2);
        addv(O_ORI, 1, 1,  C_DEC, 0, 0, 2);
        addv(O_ADDI,1, 8,  C_EXIO,0, 0, 2);
        addv(O_R,   1, 9,  C_WBI, 0, 0, 2);
        addv(O_R,   1, 0,  C_F1,  1, 0, 3);
        addv(O_BEQ, 1, 1,  C_DEC, 0, 0, 3);
        addv(O_J,   1, 10, C_BR,  0, 0, 3);
        addv(O_R,   1, 0,  C_F1,  1, 0, 4);
        addv(O_J,   1, 1,  C_DEC, 0, 0, 4);
        addv(O_R,   1, 11, C_J,   0, 0, 4);
        addv(O_R,   0, 0,  C_F0,  1, 0, 5);
        addv(O_R,   0, 0,  C_F0,  0, 0, 5);
        addv(O_R,   1, 0,  C_F1,  0, 0, 5);
        addv(O_LW,  0, 1,  C_DEC, 0, 0, 5);
        addv(O_SW,  0, 2,  C_MADR,0, 0, 5);
        addv(O_R,   0, 3,  C_MRD, 0, 0, 5);
        addv(O_R,   0, 3,  C_MRD, 0, 0, 5);
        addv(O_R,   1, 3,  C_MRD, 0, 0, 5);
        addv(O_R,   0, 4,  C_WBM, 0, 0, 5);
        addv(O_R,   1, 0,  C_F1,  1, 0, 6);
        addv(O_BAD, 0, 1,  C_DEC, 0, 0, 6);
        addv(O_R,   0, 0,  C_F0,  0, 1, 6);
        addv(O_R,   0, 0,  C_F0,  0, 0, 6);

        // reset state
        rst_n = 1'b0; op = '0; mem_ready = 1'b0;
        #3;
        chk("rst state", int'(state_o), 0);
        chk("rst instr_cnt", int'(instr_cnt), 0);
        chk("rst retire", int'(retire), 0);
        chk("rst illegal", int'(illegal), 0);
        chk("rst ctrl", int'(dutC), int'(C_F0));
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vq[i]) begin
            @(negedge clk);
            op = vq[i].op;
            mem_ready = vq[i].rdy;
            #1;
            chk($sformatf("vec%0d state", i), int'(state_o), vq[i].st);
            chk($sformatf("vec%0d ctrl", i), int'(dutC), int'(vq[i].c));
            chk($sformatf("vec%0d retire", i), int'(retire), int'(vq[i].ret));
            chk($sformatf("vec%0d illegal", i), int'(illegal), int'(vq[i].ill));
            chk($sformatf("vec%0d instr_cnt", i), int'(instr_cnt), vq[i].cnt);
        end

        // reset in the middle of a store with MemWr asserted
        @(negedge clk); mem_ready = 1'b1; op = O_R;
        @(negedge clk); mem_ready = 1'b0; op = O_SW;
        @(negedge clk); op = O_R;
        @(negedge clk);
        #1;
        chk("midrst pre state", int'(state_o), 5);
        chk("midrst pre MemWr", int'(MemWr), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst state", int'(state_o), 0);
        chk("midrst MemWr", int'(MemWr), 0);
        chk("midrst instr_cnt", int'(instr_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post-rst state", int'(state_o), 0);
        chk("post-rst MemRd", int'(MemRd), 1);
        mCnt = '0; pendRet = 0; pendIll = 0;

        // randomized instruction stream with random wait states
        for (int n = 0; n < 150; n++) begin
            logic [5:0] o;
            int sel;
            sel = $urandom_range(0, 8);
            case (sel)
                0: o = O_R;     1: o = O_LW;    2: o = O_SW;
                3: o = O_ORI;   4: o = O_ADDIU; 5: o = O_ADDI;
                6: o = O_BEQ;   7: o = O_J;
                default: begin
                    o = 6'($urandom);
                    while (isLegal(o)) o = 6'($urandom);
                end
            endcase
            runInstr(o, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // enough back-to-back jumps to wrap the counter at least once
        for (int n = 0; n < (1 << CW) + 4; n++) runInstr(O_J, 0, 0);
        runInstr(O_BEQ, 0, 0);

        $display("Result: errors=%0d of %0d checks", nErr, nChk);
        $finish;
    end

endmodule
